// File: rtl/nios2_subsystem_pio_ram_readback.sv
// Avalon-MM readback of the visualizer RAM: an ADDR write launches a req/ack read, and the
// returned word is held in DATA with VALID/TMO/OVR status and a level irq.
module nios2_subsystem_pio_ram_readback #(
  parameter int DATA_W  = 6,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_req,
  input  logic              ram_rd_ack,
  input  logic [DATA_W-1:0] ram_rd_data
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_valid, r_tmo, r_ovr;
  logic [2:0]          r_ctrl;
  logic                w_wr, w_rd, w_start, w_ack, w_tmo_hit, w_data_rd, w_stat_wr, w_busy;
  logic                w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_rd      = chipselect & ~read_n;
  assign w_data_rd = w_rd && (address == 2'd0);
  assign w_stat_wr = w_wr && (address == 2'd2);
  // ADDR writes only count in IDLE; a write while busy must not disturb the transaction
  assign w_start   = (r_state == S_IDLE) && w_wr && (address == 2'd1);
  assign w_ack     = (r_state == S_REQ) && ram_rd_ack;
  assign w_tmo_hit = (r_state == S_REQ) && !ram_rd_ack && (r_cnt == CNT_LAST);
  assign w_unused  = &{1'b0, writedata[31:ADDR_W]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ram_rd_req  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_REQ;
      S_REQ: begin
        ram_rd_req = 1'b1;
        w_busy     = 1'b1;
        if (w_ack || w_tmo_hit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_tmo   <= 1'b0;
      r_ovr   <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      if (w_start)                   r_addr <= writedata[ADDR_W-1:0];
      else if (w_ack && r_ctrl[2])   r_addr <= r_addr + ADDR_ONE;

      if (w_start)                   r_cnt <= '0;
      else if (r_state == S_REQ)     r_cnt <= r_cnt + 8'd1;

      if (w_ack)                     r_data <= ram_rd_data;

      // a fresh word outranks the clear from a same-cycle DATA read
      if (w_ack)                     r_valid <= 1'b1;
      else if (w_data_rd)            r_valid <= 1'b0;

      if (w_tmo_hit)                 r_tmo <= 1'b1;
      else if (w_stat_wr && writedata[2]) r_tmo <= 1'b0;

      if (w_ack && r_valid && !w_data_rd) r_ovr <= 1'b1;
      else if (w_stat_wr && writedata[3]) r_ovr <= 1'b0;

      if (w_wr && (address == 2'd3)) r_ctrl <= writedata[2:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = 32'(r_data);
      2'd1: readdata = 32'(r_addr);
      2'd2: readdata = {28'd0, r_ovr, r_tmo, w_busy, r_valid};
      2'd3: readdata = {29'd0, r_ctrl};
      default: readdata = '0;
    endcase
  end

  assign ram_addr = r_addr;
  assign irq      = (r_valid & r_ctrl[0]) | (r_tmo & r_ctrl[1]);

endmodule

// File: tb/tb_nios2_subsystem_pio_ram_readback.sv
// Directed bench for the RAM readback slave: expected register reads go into a scoreboard queue
// that a negedge monitor drains; request length, irq and reset behaviour are checked inline.
module tb_nios2_subsystem_pio_ram_readback;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [9:0]  ram_addr;
  logic        ram_rd_req;
  logic        ram_rd_ack = 1'b0;
  logic [5:0]  ram_rd_data = '0;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  nios2_subsystem_pio_ram_readback #(.DATA_W(6), .ADDR_W(10), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .ram_addr(ram_addr), .ram_rd_req(ram_rd_req), .ram_rd_ack(ram_rd_ack),
    .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Monitor: every read strobe seen away from the edge consumes one expected value.
  always @(negedge clk) begin
    if (ram_rd_req) req_cycles <= req_cycles + 1;
    if (chipselect && !read_n) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_read addr=%0d got=0x%0h expected=none", address, readdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        if (readdata !== e) begin
          errors = errors + 1;
          $display("FAIL %s got=0x%0h expected=0x%0h", n, readdata, e);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=0x%0h expected=0x%0h", n, got, exp);
    end
  endtask

  // All bus tasks start just after an edge and end just after the edge that sampled them.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e); name_q.push_back(n);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  // Ack sampled at the end of request cycle n (n=1 is the first cycle with req high).
  task automatic give_ack(input int n, input logic [5:0] d);
    repeat (n - 1) begin @(posedge clk); #1; end
    ram_rd_ack = 1'b1; ram_rd_data = d;
    @(posedge clk); #1;
    ram_rd_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_req", {31'd0, ram_rd_req}, 32'd0);
    bus_read(2'd0, 32'h0, "rst_data");
    bus_read(2'd1, 32'h0, "rst_addr");
    bus_read(2'd2, 32'h0, "rst_status");
    bus_read(2'd3, 32'h0, "rst_ctrl");

    // basic read, ack on the third request cycle
    req_cycles = 0;
    bus_write(2'd1, 32'h005);
    check("ram_addr_5", {22'd0, ram_addr}, 32'h005);
    check("req_rise", {31'd0, ram_rd_req}, 32'd1);
    give_ack(3, 6'h2A);
    check("req_len_3", req_cycles, 32'd3);
    bus_read(2'd2, 32'h1, "status_valid");
    bus_read(2'd0, 32'h2A, "data_2a");
    bus_read(2'd2, 32'h0, "status_cleared");

    // timeout with TMO irq enabled
    bus_write(2'd3, 32'h2);
    req_cycles = 0;
    bus_write(2'd1, 32'h007);
    repeat (6) begin @(posedge clk); #1; end
    check("req_len_tmo", req_cycles, 32'd4);
    check("irq_tmo", {31'd0, irq}, 32'd1);
    bus_read(2'd2, 32'h4, "status_tmo");
    bus_write(2'd2, 32'h4);
    check("irq_tmo_clr", {31'd0, irq}, 32'd0);
    bus_read(2'd2, 32'h0, "status_tmo_clr");

    // autoinc wrap, then overrun
    bus_write(2'd3, 32'h4);
    bus_write(2'd1, 32'h3FF);
    give_ack(1, 6'h11);
    bus_read(2'd1, 32'h000, "addr_wrap");
    bus_write(2'd1, 32'h123);
    give_ack(2, 6'h22);
    bus_read(2'd2, 32'h9, "status_ovr");
    bus_read(2'd0, 32'h22, "data_22");
    bus_read(2'd1, 32'h124, "addr_inc");
    bus_read(2'd2, 32'h8, "status_ovr_only");
    bus_write(2'd2, 32'h8);
    bus_read(2'd2, 32'h0, "status_ovr_clr");

    // write while busy ignored; ack coincident with DATA read
    bus_write(2'd3, 32'h0);
    bus_write(2'd1, 32'h020);
    give_ack(1, 6'h15);
    req_cycles = 0;
    bus_write(2'd1, 32'h040);
    bus_write(2'd1, 32'h010);
    check("busy_addr_kept", {22'd0, ram_addr}, 32'h040);
    exp_q.push_back(32'h15); name_q.push_back("data_old_on_ack");
    ram_rd_ack = 1'b1; ram_rd_data = 6'h2C;
    chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
    @(posedge clk); #1;
    ram_rd_ack = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    check("req_len_busy", req_cycles, 32'd2);
    bus_read(2'd2, 32'h1, "status_coincident");
    bus_read(2'd1, 32'h040, "addr_after_busy");
    bus_read(2'd0, 32'h2C, "data_2c");

    // asynchronous reset in the middle of a request
    bus_write(2'd3, 32'h3);
    bus_write(2'd1, 32'h055);
    check("req_before_rst", {31'd0, ram_rd_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("req_async_drop", {31'd0, ram_rd_req}, 32'd0);
    check("ram_addr_rst", {22'd0, ram_addr}, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(2'd0, 32'h0, "post_rst_data");
    bus_read(2'd1, 32'h0, "post_rst_addr");
    bus_read(2'd2, 32'h0, "post_rst_status");
    bus_read(2'd3, 32'h0, "post_rst_ctrl");
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    repeat (2) @(posedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nios2_subsystem_pio_ram_readback.md
# nios2_subsystem_pio_ram_readback

Avalon-MM slave that lets the Nios II read back the 6-bit visualizer RAM contents written through the RAM data PIO. The CPU writes a RAM address, and the block runs a req/ack read transaction toward the fabric-side RAM port. It latches the returned word into a holding register and flags completion, timeout or overrun through a status register and an optional interrupt.

## Interface
Parameters:
- DATA_W, 6: RAM data width; readdata is zero-extended to 32 bits.
- ADDR_W, 10: RAM address width.
- TIMEOUT, 255: maximum number of cycles ram_rd_req stays high waiting for ram_rd_ack; range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  Avalon word address.
- chipselect  in  1  Avalon select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational (zero wait states).
- irq  out  1  level interrupt to the CPU.
- ram_addr  out  ADDR_W  RAM read address, driven from the ADDR register.
- ram_rd_req  out  1  read request, held until ack or timeout.
- ram_rd_ack  in  1  one-cycle acknowledge; ram_rd_data is valid in the same cycle.
- ram_rd_data  in  DATA_W  returned RAM word.

## Operation
Register map (wr = chipselect & ~write_n, rd = chipselect & ~read_n):
- 0 DATA, RO: holding register. A read clears VALID at the next edge. Writes are ignored.
- 1 ADDR, RW: bits [ADDR_W-1:0].
  - A write in IDLE loads the address and starts a request.
  - A write while BUSY is fully ignored: the address is unchanged and no request starts.
- 2 STATUS:
  - bit0 VALID (RO), bit1 BUSY (RO).
  - bit2 TMO (W1C), bit3 OVR (W1C).
  - Other bits read 0.
- 3 CTRL, RW:
  - bit0 irq enable for VALID, bit1 irq enable for TMO.
  - bit2 AUTOINC: ADDR increments after each acked read, wrapping from 2^ADDR_W-1 to 0.
- irq = (VALID & CTRL[0]) | (TMO & CTRL[1]).

FSM, two states:
- IDLE: ram_rd_req = 0; ram_rd_ack is ignored. A write to ADDR transitions to REQ and clears the timeout counter.
- REQ: ram_rd_req = 1, BUSY = 1; the counter increments each cycle.
  - If ram_rd_ack = 1: latch ram_rd_data into DATA, set VALID, apply AUTOINC, go to IDLE.
  - Else if the counter reaches TIMEOUT-1: set TMO, go to IDLE. DATA and VALID are unchanged.
- OVR is set when an ack arrives while VALID = 1 and no DATA read occurs in the same cycle.

Boundary rules:
- Ack and DATA read in the same cycle: readdata returns the old word, DATA takes the new word, VALID stays 1, OVR is not set.
- A W1C write to TMO in the same cycle a timeout sets TMO: set wins.
- An ADDR write in the same cycle as completion is ignored, because the FSM is still in REQ.
- Reset mid-transaction: ram_rd_req drops asynchronously and all state returns to reset values.

Reset values: every register is 0, the FSM is in IDLE, and ram_rd_req, ram_addr, irq and readdata are all 0.

## Timing
- ADDR write at edge N: ram_addr updates and ram_rd_req rises after edge N.
- An ack sampled at edge N+k (k ≥ 1) drops ram_rd_req after that edge. VALID, DATA and irq update after the same edge.
  - Minimum CPU-visible latency from the ADDR write to VALID = 1 is 2 edges.
- Timeout: ram_rd_req stays high for exactly TIMEOUT cycles, then TMO = 1 on the following cycle.
- readdata is purely combinational from address and registers; there is no read latency.
- Status bits and irq are registered, with no combinational path from ram_rd_ack.

## Test plan
- Reset, then read all 4 registers -> each reads 0x0; irq = 0 and ram_rd_req = 0.
- Write ADDR = 0x005, then ack on the 3rd req cycle with data 0x2A -> req is high for exactly 3 cycles; STATUS = 0x1; DATA reads 0x2A; STATUS reads 0x0 after the DATA read.
- TIMEOUT = 4, CTRL = 0x2, write ADDR with no ack -> req is high for 4 cycles; STATUS = 0x4 and irq = 1; writing STATUS = 0x4 clears TMO and irq.
- CTRL = 0x4, ADDR = 0x3FF, ack with data 0x11 -> ADDR reads 0x000. A second read without reading DATA, acked with 0x22 -> STATUS = 0x9 and DATA = 0x22.
- Write ADDR = 0x010 while BUSY -> ADDR keeps the old value and req length is unaffected. Ack coincides with a DATA read -> readdata returns the old word, VALID = 1, OVR = 0.
- Assert reset_n = 0 mid-REQ -> ram_rd_req drops within the reset cycle without waiting for a clock edge, and all registers read 0 after release.
